multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU; replaces the single-cycle instruction decode so the ALU, register file and unified memory are reused across steps.
- Decodes opcode/funct and sequences FETCH/DECODE/EXEC/MEM/WB, driving all datapath enables and muxes.
- Handles a memory req/ready handshake, with a watchdog, and traps on overflow or an illegal instruction.

Parameters:
- TIMEOUT, 16, max cycles waiting on mem_ready before trapping; 0 disables the watchdog.

Ports:
- clk in 1 system clock, all state on rising edge.
- rst_n in 1 synchronous active-low reset.
- opcode in 6 IR[31:26].
- funct in 6 IR[5:0].
- zero in 1 ALU zero flag.
- overflow in 1 ALU signed overflow flag.
- mem_ready in 1 memory completes the current request this cycle.
- mem_req out 1 memory access request.
- IorD out 1 memory address source: 0 = PC, 1 = ALUOut.
- IRWr out 1 instruction register write.
- PCWr out 1 PC write.
- PCsrc out 2 PC source: 00 ALU, 01 ALUOut branch target, 10 jump target, 11 rs.
- MemWr out 1 memory write.
- RegWr out 1 register file write.
- RegDst out 2 destination register: 00 rt, 01 rd, 10 $31.
- MemToReg out 2 write-back data: 00 ALUOut, 01 MDR, 10 PC.
- ALUsrcA out 1 ALU A input: 0 = PC, 1 = rs.
- ALUsrcB out 2 ALU B input: 00 rt, 01 const 4, 10 extended imm, 11 sext imm<<2.
- ImmZext out 1 immediate extension: 1 = zero-extend, 0 = sign-extend.
- ALUctrl out 3 ALU operation: 000 ADD, 001 SUB, 010 XOR, 011 SLT.
- instr_done out 1 one-cycle pulse when an instruction retires.
- err out 1 sticky trap flag.
- err_code out 2 trap cause: 01 overflow, 10 illegal, 11 timeout.

Behaviour:
- Reset: rst_n low at a rising edge puts state in IDLE and clears err, err_code and the watchdog. IDLE drives all outputs 0 and moves to FETCH unconditionally.
- Reset mid-operation, e.g. during MEM_WR, aborts the access; mem_req falls the cycle after the edge.
- Outputs are combinational from state. Exceptions: IRWr, PCWr and the write enables are additionally qualified by mem_ready, zero and overflow as stated per state.
- Decode:
  - LW 0x23, SW 0x2B.
  - BEQ 0x04, BNE 0x05.
  - J 0x02, JAL 0x03.
  - ADDI 0x08, XORI 0x0E.
  - R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
  - Anything else goes to TRAP with code 10.
- FETCH: mem_req=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ADD, PCsrc=00. IRWr and PCWr equal mem_ready. Go to DECODE on mem_ready; otherwise hold.
- DECODE: ALUsrcA=0, ALUsrcB=11, ADD (precomputes the branch target into ALUOut). Next state by opcode/funct.
- EXEC_R: ALUsrcA=1, ALUsrcB=00, ALUctrl from funct. Go to WB_R, or to TRAP (code 01) if overflow and funct is ADD or SUB.
- EXEC_I: ALUsrcA=1, ALUsrcB=10. ADDI uses ADD with ImmZext=0; XORI uses XOR with ImmZext=1. Go to WB_I, or to TRAP (code 01) if ADDI and overflow.
- A trapped instruction never writes the register file.
- WB_R: RegWr=1, RegDst=01, MemToReg=00, instr_done=1, then FETCH.
- WB_I: RegWr=1, RegDst=00, MemToReg=00, instr_done=1, then FETCH.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ADD. Go to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, IorD=1. Hold until mem_ready, then WB_MEM.
- WB_MEM: RegWr=1, RegDst=00, MemToReg=01, instr_done=1, then FETCH.
- MEM_WR: mem_req=1, IorD=1, MemWr=1. Hold until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, SUB, PCsrc=01. PCWr = zero for BEQ, ~zero for BNE; overflow is ignored. instr_done=1, then FETCH.
- JUMP: PCWr=1, PCsrc=10.
- JAL: PCWr=1, PCsrc=10, RegWr=1, RegDst=10, MemToReg=10. The link value is the current PC, already PC+4 after FETCH.
- JR: PCWr=1, PCsrc=11.
- JUMP, JAL and JR each assert instr_done=1 and go to FETCH.
- Watchdog: counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0, and clears on any state change. When the count reaches TIMEOUT, go to TRAP with code 11. With TIMEOUT=0 the watchdog never fires.
- TRAP: err=1, err_code held, all enables and mem_req 0. Exit only via reset.
- Latency with mem_ready tied high:
  - R-type and ADDI/XORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE, J, JAL, JR: 3 cycles.

Test Plan:
- ADD with no overflow, mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_R; RegWr=1 and RegDst=01 only in the 4th cycle; instr_done pulses once.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_req held 4 cycles; WB_MEM shows MemToReg=01, RegWr=1; total latency 8 cycles.
- BEQ with zero=1 -> PCWr=1, PCsrc=01. BNE with zero=1 -> PCWr=0. Both return to FETCH after 3 cycles.
- ADDI with overflow=1 in EXEC_I -> TRAP, err=1, err_code=01, RegWr never asserted; opcode 0x3F -> err_code=10.
- TIMEOUT=16, mem_ready held 0 in FETCH -> TRAP after 16 waiting cycles, err_code=11.
- Reset:
  - rst_n low during MEM_WR -> next cycle IDLE with all outputs 0, then FETCH.
  - rst_n low in TRAP -> err clears.
- JAL -> RegDst=10, MemToReg=10, RegWr=1, PCWr=1, PCsrc=10 in the same cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control sequencer for the multi-cycle MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// enables and mux selects, and traps on overflow, illegal opcodes or a stalled
// memory (watchdog).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] PCsrc,
  output logic       MemWr,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic       ImmZext,
  output logic [2:0] ALUctrl,
  output logic       instr_done,
  output logic       err,
  output logic [1:0] err_code
);

  // Watchdog counter wide enough to hold TIMEOUT-1; at least one bit.
  localparam int unsigned WD_W = $clog2(TIMEOUT + 32'd2);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] TRAP_OVF  = 2'b01;
  localparam logic [1:0] TRAP_ILL  = 2'b10;
  localparam logic [1:0] TRAP_WDOG = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        trap_code_s;
  logic              wait_s;
  logic              wd_hit_s;

  // Next state, trap capture and watchdog bookkeeping.
  always_comb begin
    state_d     = state_q;
    trap_code_s = 2'b00;
    wd_d        = {WD_W{1'b0}};
    wait_s      = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                  && !mem_ready;
    wd_hit_s    = (TIMEOUT != 32'd0) && ((32'(wd_q) + 32'd1) == 32'(TIMEOUT));

    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              F_ADD, F_SUB, F_SLT: state_d = S_EXEC_R;
              F_JR:                state_d = S_JR;
              default: begin
                state_d     = S_TRAP;
                trap_code_s = TRAP_ILL;
              end
            endcase
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          default: begin
            state_d     = S_TRAP;
            trap_code_s = TRAP_ILL;
          end
        endcase
      end
      S_EXEC_R: begin
        if (overflow && ((funct == F_ADD) || (funct == F_SUB))) begin
          state_d     = S_TRAP;
          trap_code_s = TRAP_OVF;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (overflow && (opcode == OP_ADDI)) begin
          state_d     = S_TRAP;
          trap_code_s = TRAP_OVF;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase

    // A stall keeps the count running; any state change restarts it.
    if (wait_s) begin
      if (wd_hit_s) begin
        state_d     = S_TRAP;
        trap_code_s = TRAP_WDOG;
        wd_d        = {WD_W{1'b0}};
      end else begin
        wd_d = wd_q + WD_W'(1'b1);
      end
    end else begin
      wd_d = {WD_W{1'b0}};
    end

    // The cause is latched only on the transition into TRAP.
    if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
      err_d      = 1'b1;
      err_code_d = trap_code_s;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    PCsrc      = 2'b00;
    MemWr      = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 2'b00;
    MemToReg   = 2'b00;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    ImmZext    = 1'b0;
    ALUctrl    = ALU_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUsrcB = 2'b01;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
      end
      S_DECODE:   ALUsrcB = 2'b11;
      S_EXEC_R: begin
        ALUsrcA = 1'b1;
        case (funct)
          F_SUB:   ALUctrl = ALU_SUB;
          F_SLT:   ALUctrl = ALU_SLT;
          default: ALUctrl = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        if (opcode == OP_XORI) begin
          ALUctrl = ALU_XOR;
          ImmZext = 1'b1;
        end else begin
          ALUctrl = ALU_ADD;
          ImmZext = 1'b0;
        end
      end
      S_WB_R: begin
        RegWr      = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWr      = 1'b1;
        MemToReg   = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemWr      = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUctrl    = ALU_SUB;
        PCsrc      = 2'b01;
        PCWr       = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWr       = 1'b1;
        PCsrc      = 2'b10;
        instr_done = 1'b1;
      end
      S_JAL: begin
        PCWr       = 1'b1;
        PCsrc      = 2'b10;
        RegWr      = 1'b1;
        RegDst     = 2'b10;
        MemToReg   = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        PCWr       = 1'b1;
        PCsrc      = 2'b11;
        instr_done = 1'b1;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign err      = err_q;
  assign err_code = err_code_q;

  // State, trap flag and watchdog registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      wd_q       <= {WD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wd_q       <= wd_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: the stimulus side predicts
// per-instruction outcomes (latency, enable counts, trap cause) and queues them;
// a negedge monitor gathers the same figures from the DUT and compares.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 16;

  localparam int K_RST = 0, K_DONE = 1, K_TRAP = 2;
  localparam int T_ADD = 0, T_SUB = 1, T_SLT = 2, T_JR = 3, T_ADDI = 4, T_XORI = 5,
                 T_LW = 6, T_SW = 7, T_BEQ = 8, T_BNE = 9, T_J = 10, T_JAL = 11,
                 T_ILLO = 12, T_ILLF = 13;

  logic clk = 1'b0;
  logic rst_n, zero, overflow, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, IorD, IRWr, PCWr, MemWr, RegWr, ALUsrcA, ImmZext, instr_done, err;
  logic [1:0] PCsrc, RegDst, MemToReg, ALUsrcB, err_code;
  logic [2:0] ALUctrl;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
    .IRWr(IRWr), .PCWr(PCWr), .PCsrc(PCsrc), .MemWr(MemWr), .RegWr(RegWr),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .ImmZext(ImmZext), .ALUctrl(ALUctrl), .instr_done(instr_done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; int lat; int code;
    int n_memreq; int n_irwr; int n_pcwr; int pcsrc; int n_memwr;
    int n_regwr; int dst; int m2r; int n_both; int n_iord;
    int n_rsa; int rs_op; int rs_b; int rs_z;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] illo [6] = '{6'h3F, 6'h01, 6'h10, 6'h24, 6'h0C, 6'h06};
  logic [5:0] illf [6] = '{6'h00, 6'h21, 6'h23, 6'h24, 6'h26, 6'h3F};

  wire [21:0] outs_s = {mem_req, IorD, IRWr, PCWr, PCsrc, MemWr, RegWr, RegDst, MemToReg,
                        ALUsrcA, ALUsrcB, ImmZext, ALUctrl, instr_done, err, err_code};
  wire [5:0]  en_s   = {mem_req, IRWr, PCWr, MemWr, RegWr, instr_done};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected outcome of one instruction, from the per-instruction step rules.
  function automatic exp_t model(int t, bit z, bit ov, int fs, int ms);
    exp_t e;
    bit taken;
    e = '{default: 0};
    e.kind = K_DONE;
    e.lat = fs + 2;          // fetch incl. stalls, then decode
    e.n_memreq = fs + 1;
    e.n_irwr = 1;
    e.n_pcwr = 1;
    case (t)
      T_ADD, T_SUB, T_SLT: begin
        e.n_rsa = 1;
        e.rs_op = (t == T_ADD) ? 0 : ((t == T_SUB) ? 1 : 3);
        if (ov && (t != T_SLT)) begin e.kind = K_TRAP; e.code = 1; e.lat += 1; end
        else begin e.lat += 2; e.n_regwr = 1; e.dst = 1; end
      end
      T_ADDI, T_XORI: begin
        e.n_rsa = 1; e.rs_b = 2;
        e.rs_op = (t == T_ADDI) ? 0 : 2;
        e.rs_z  = (t == T_XORI) ? 1 : 0;
        if (ov && (t == T_ADDI)) begin e.kind = K_TRAP; e.code = 1; e.lat += 1; end
        else begin e.lat += 2; e.n_regwr = 1; end
      end
      T_LW: begin
        e.n_rsa = 1; e.rs_b = 2;
        e.lat += 1 + (ms + 1) + 1;
        e.n_memreq += ms + 1; e.n_iord = ms + 1;
        e.n_regwr = 1; e.m2r = 1;
      end
      T_SW: begin
        e.n_rsa = 1; e.rs_b = 2;
        e.lat += 1 + (ms + 1);
        e.n_memreq += ms + 1; e.n_iord = ms + 1; e.n_memwr = ms + 1;
      end
      T_BEQ, T_BNE: begin
        e.n_rsa = 1; e.rs_op = 1;
        e.lat += 1;
        taken = (t == T_BEQ) ? z : !z;
        if (taken) begin e.n_pcwr = 2; e.pcsrc = 1; end
      end
      T_J:   begin e.lat += 1; e.n_pcwr = 2; e.pcsrc = 2; end
      T_JAL: begin
        e.lat += 1; e.n_pcwr = 2; e.pcsrc = 2;
        e.n_regwr = 1; e.dst = 2; e.m2r = 2; e.n_both = 1;
      end
      T_JR:  begin e.lat += 1; e.n_pcwr = 2; e.pcsrc = 3; end
      default: begin e.kind = K_TRAP; e.code = 2; end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    e = '{default: 0};
    e.kind = K_RST;
    exp_q.push_back(e);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_instr(int t, bit z, bit ov, int fs, int ms, int ill_sel);
    exp_t e;
    int mem_start;
    e = model(t, z, ov, fs, ms);
    exp_q.push_back(e);
    funct = 6'($urandom_range(0, 63));
    case (t)
      T_ADD:  begin opcode = 6'h00; funct = 6'h20; end
      T_SUB:  begin opcode = 6'h00; funct = 6'h22; end
      T_SLT:  begin opcode = 6'h00; funct = 6'h2A; end
      T_JR:   begin opcode = 6'h00; funct = 6'h08; end
      T_ADDI: opcode = 6'h08;
      T_XORI: opcode = 6'h0E;
      T_LW:   opcode = 6'h23;
      T_SW:   opcode = 6'h2B;
      T_BEQ:  opcode = 6'h04;
      T_BNE:  opcode = 6'h05;
      T_J:    opcode = 6'h02;
      T_JAL:  opcode = 6'h03;
      T_ILLO: opcode = illo[(ill_sel >= 0) ? ill_sel : $urandom_range(0, 5)];
      default: begin opcode = 6'h00; funct = illf[$urandom_range(0, 5)]; end
    endcase
    zero = z;
    overflow = ov;
    mem_start = fs + 3;
    for (int i = 0; i < e.lat; i++) begin
      if (i < fs) mem_ready = 1'b0;
      else if (i == fs) mem_ready = 1'b1;
      else if ((t == T_LW || t == T_SW) && i >= mem_start && i < mem_start + ms) mem_ready = 1'b0;
      else if ((t == T_LW || t == T_SW) && i == mem_start + ms) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    if (e.kind == K_TRAP) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
      do_reset();
    end
  endtask

  function automatic int rand_stall();
    return ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
  endfunction

  // Monitor state: per-instruction observations gathered from the DUT.
  int cyc, a_memreq, a_irwr, a_pcwr, a_pcsrc, a_memwr, a_regwr, a_dst, a_m2r;
  int a_both, a_iord, a_rsa, a_rs_op, a_rs_b, a_rs_z;
  bit idle_pend = 1'b0;
  bit trapped = 1'b0;

  function automatic void clr();
    cyc = 0; a_memreq = 0; a_irwr = 0; a_pcwr = 0; a_pcsrc = 0; a_memwr = 0;
    a_regwr = 0; a_dst = 0; a_m2r = 0; a_both = 0; a_iord = 0;
    a_rsa = 0; a_rs_op = 0; a_rs_b = 0; a_rs_z = 0;
  endfunction

  task automatic pop_ev(input int kind, output bit ok, output exp_t e);
    ok = 1'b0;
    e = '{default: 0};
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  task automatic chk_fields(input exp_t e);
    chk("latency", cyc, e.lat);
    chk("mem_req_cycles", a_memreq, e.n_memreq);
    chk("irwr_cycles", a_irwr, e.n_irwr);
    chk("pcwr_cycles", a_pcwr, e.n_pcwr);
    chk("pcsrc", a_pcsrc, e.pcsrc);
    chk("memwr_cycles", a_memwr, e.n_memwr);
    chk("regwr_cycles", a_regwr, e.n_regwr);
    chk("regdst", a_dst, e.dst);
    chk("memtoreg", a_m2r, e.m2r);
    chk("regwr_with_pcwr", a_both, e.n_both);
    chk("iord_cycles", a_iord, e.n_iord);
    chk("rs_alu_cycles", a_rsa, e.n_rsa);
    chk("rs_alu_op", a_rs_op, e.rs_op);
    chk("rs_alu_srcb", a_rs_b, e.rs_b);
    chk("immzext", a_rs_z, e.rs_z);
  endtask

  // Monitor: samples on the falling edge and checks against the queue.
  initial begin
    exp_t e;
    bit ok;
    clr();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b0) begin
        clr(); idle_pend = 1'b1; trapped = 1'b0;
      end else if (idle_pend) begin
        idle_pend = 1'b0;
        pop_ev(K_RST, ok, e);
        if (ok) begin
          chk("idle_outputs", 32'(outs_s), 32'd0);
          chk("idle_err", 32'(err), 32'd0);
        end
        clr();
      end else if (trapped) begin
        chk("trap_err_held", 32'(err), 32'd1);
        chk("trap_enables", 32'(en_s), 32'd0);
      end else if (err === 1'b1) begin
        trapped = 1'b1;
        pop_ev(K_TRAP, ok, e);
        if (ok) begin
          chk("err_code", 32'(err_code), e.code);
          chk("trap_enables", 32'(en_s), 32'd0);
          chk_fields(e);
        end
        clr();
      end else begin
        cyc++;
        if (mem_req) a_memreq++;
        if (IRWr) a_irwr++;
        if (PCWr) begin a_pcwr++; a_pcsrc = PCsrc; end
        if (MemWr) a_memwr++;
        if (RegWr) begin a_regwr++; a_dst = RegDst; a_m2r = MemToReg; end
        if (RegWr && PCWr) a_both++;
        if (IorD) a_iord++;
        if (ALUsrcA) begin a_rsa++; a_rs_op = ALUctrl; a_rs_b = ALUsrcB; a_rs_z = ImmZext; end
        if (instr_done === 1'b1) begin
          pop_ev(K_DONE, ok, e);
          if (ok) chk_fields(e);
          clr();
        end
      end
    end
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL time_guard: got no finish expected finish before %0t", $time);
    $fatal(1, "time guard expired");
  end

  // Stimulus: directed cases first, then a randomized instruction stream.
  initial begin
    exp_t e;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; overflow = 1'b0;
    step();
    do_reset();

    run_instr(T_ADD, 1'b0, 1'b0, 0, 0, -1);
    run_instr(T_LW, 1'b0, 1'b0, 0, 3, -1);
    run_instr(T_BEQ, 1'b1, 1'b0, 0, 0, -1);
    run_instr(T_BNE, 1'b1, 1'b0, 0, 0, -1);
    run_instr(T_JAL, 1'b0, 1'b0, 0, 0, -1);
    run_instr(T_SW, 1'b0, 1'b0, 15, 15, -1);
    run_instr(T_ADDI, 1'b0, 1'b1, 0, 0, -1);
    run_instr(T_ILLO, 1'b0, 1'b0, 0, 0, 0);

    // Watchdog: memory never answers the fetch.
    e = '{default: 0};
    e.kind = K_TRAP; e.code = 3; e.lat = TO; e.n_memreq = TO;
    exp_q.push_back(e);
    mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) step();
    step();
    do_reset();

    // Reset while a store is waiting in the write step.
    opcode = 6'h2B; zero = 1'b0; overflow = 1'b0;
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; step();
    step();
    step();
    step();
    do_reset();

    for (int k = 0; k < 250; k++) begin
      int t;
      t = $urandom_range(0, 13);
      run_instr(t, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                rand_stall(), rand_stall(), -1);
    end

    step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
